// File: rtl/instr_fetch.sv
// Instruction sequencer: loadable program store, program counter and IDLE/RUN/HALT
// run control. Issues one registered instruction per cycle with stall, branch and halt.
module instr_fetch #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter logic [3:0]             HALT_OP     = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   run,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [PC_BITS-1:0]     branch_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted
);

  localparam int DEPTH = 1 << PC_BITS;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 r_state, w_state_next;
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic [PC_BITS-1:0]     r_pc, w_pc_next;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_next;
  logic                   r_valid, w_valid_next;
  logic                   w_mem_we;
  logic [INSTR_WIDTH-1:0] w_fetch;
  logic                   w_halt_issued;

  assign w_fetch = r_mem[r_pc];
  // The halt word is on the output this cycle; fetch stops once it is accepted.
  assign w_halt_issued = r_valid && (r_instr[INSTR_WIDTH-1 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_valid_next = r_valid;
    w_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        w_mem_we = load_en;
        if (run) w_state_next = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (w_halt_issued) begin
            w_state_next = HALT;
            w_instr_next = NOP_INSTR;
            w_valid_next = 1'b0;
          end else if (branch_en) begin
            w_pc_next    = branch_target;
            w_instr_next = NOP_INSTR;
            w_valid_next = 1'b0;
          end else begin
            w_instr_next = w_fetch;
            w_valid_next = 1'b1;
            w_pc_next    = r_pc + PC_BITS'(1);
          end
        end
      end
      HALT: begin
        w_mem_we     = load_en;
        w_instr_next = NOP_INSTR;
        w_valid_next = 1'b0;
        if (run) begin
          w_pc_next    = '0;
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pc_next    = '0;
        w_instr_next = NOP_INSTR;
        w_valid_next = 1'b0;
      end
    endcase
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam int W  = 20;
  localparam int PB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en, run, stall, branch_en;
  logic [PB-1:0] load_addr, branch_target;
  logic [W-1:0]  load_data;
  logic [W-1:0]  instruction;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          halted;

  instr_fetch #(.INSTR_WIDTH(W), .PC_BITS(PB)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .run(run), .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: mode 0=idle, 1=running, 2=halted
  logic [W-1:0] ref_mem [32];
  int           ref_mode;
  int           ref_pc;
  logic [W-1:0] ref_instr;
  logic         ref_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    ref_mode  = 0;
    ref_pc    = 0;
    ref_instr = '0;
    ref_valid = 1'b0;
  endfunction

  function automatic void model_edge();
    case (ref_mode)
      0: begin
        if (load_en) ref_mem[load_addr] = load_data;
        if (run) ref_mode = 1;
      end
      1: begin
        if (!stall) begin
          if (ref_valid && ref_instr[19:16] == 4'hF) begin
            ref_mode  = 2;
            ref_instr = '0;
            ref_valid = 1'b0;
          end else if (branch_en) begin
            ref_pc    = int'(branch_target);
            ref_instr = '0;
            ref_valid = 1'b0;
          end else begin
            ref_instr = ref_mem[ref_pc];
            ref_valid = 1'b1;
            ref_pc    = (ref_pc + 1) % 32;
          end
        end
      end
      default: begin
        if (load_en) ref_mem[load_addr] = load_data;
        ref_instr = '0;
        ref_valid = 1'b0;
        if (run) begin
          ref_pc   = 0;
          ref_mode = 1;
        end
      end
    endcase
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".instr"}, instruction, ref_instr);
    check_eq({tag, ".valid"}, instr_valid, ref_valid);
    check_eq({tag, ".pc"}, pc, ref_pc);
    check_eq({tag, ".halted"}, halted, ref_mode == 2);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d %s instr=%05h v=%b pc=%0d halted=%b", cyc, tag, instruction, instr_valid, pc, halted);
    compare_all(tag);
  endtask

  task automatic load_word(input logic [PB-1:0] a, input logic [W-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick("load");
    load_en = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick("run");
    run = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    load_en = 0; run = 0; stall = 0; branch_en = 0;
    load_addr = '0; load_data = '0; branch_target = '0;
    model_reset();
    #12;
    compare_all("reset");
    check_eq("reset.instr_nop", instruction, 20'h00000);
    rst = 1'b1;

    // Sequential run with stall on the second word
    load_word(5'd0, 20'h1_0102);
    load_word(5'd1, 20'h2_0304);
    load_word(5'd2, 20'h3_0506);
    load_word(5'd3, 20'hF_0000);
    load_word(5'd10, 20'h5_00AA);
    load_word(5'd11, 20'hF_0011);
    pulse_run();
    check_eq("run.no_issue", instr_valid, 1'b0);
    tick("seq0");
    check_eq("seq0.word", instruction, 20'h1_0102);
    tick("seq1");
    check_eq("seq1.word", instruction, 20'h2_0304);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check_eq("stall.word", instruction, 20'h2_0304);
      check_eq("stall.pc", pc, 5'd2);
    end
    stall = 1'b0;
    tick("seq2");
    check_eq("seq2.word", instruction, 20'h3_0506);
    tick("seq3");
    check_eq("seq3.halt_word_valid", {instr_valid, instruction}, {1'b1, 20'hF_0000});
    tick("halt");
    check_eq("halt.state", {halted, instruction, pc}, {1'b1, 20'h00000, 5'd4});

    // Branch held under stall, then taken; load in RUN ignored
    pulse_run();
    tick("br0");
    tick("br1");
    stall = 1'b1; branch_en = 1'b1; branch_target = 5'd10;
    tick("br_stall");
    tick("br_stall");
    check_eq("br_stall.pc", pc, 5'd2);
    stall = 1'b0;
    tick("br_bubble");
    check_eq("br_bubble", {instr_valid, pc}, {1'b0, 5'd10});
    branch_en = 1'b0;
    load_en = 1'b1; load_addr = 5'd0; load_data = 20'hA_BCDE;
    tick("br_target");
    load_en = 1'b0;
    check_eq("br_target.word", instruction, 20'h5_00AA);
    tick("br_halt_word");
    tick("br_halt");
    check_eq("br_halt.halted", halted, 1'b1);

    // Wrap-around 29,30,31,0
    load_word(5'd29, 20'h6_0029);
    load_word(5'd30, 20'h7_0030);
    load_word(5'd31, 20'h8_0031);
    pulse_run();
    tick("wr_mem0");
    check_eq("run_load_ignored", instruction, 20'h1_0102);
    branch_en = 1'b1; branch_target = 5'd29;
    tick("wr_bubble");
    branch_en = 1'b0;
    tick("wr29");
    check_eq("wr29.word", instruction, 20'h6_0029);
    tick("wr30");
    tick("wr31");
    check_eq("wr31.word_pc", {instruction, pc}, {20'h8_0031, 5'd0});
    tick("wr0");
    check_eq("wr0.word_pc", {instruction, pc}, {20'h1_0102, 5'd1});
    for (int i = 0; i < 4; i++) tick("wr_tail");
    check_eq("wr_tail.halted", halted, 1'b1);

    // Simultaneous load + run from HALT, then halt again
    load_en = 1'b1; load_addr = 5'd0; load_data = 20'hF_0001; run = 1'b1;
    tick("rs_load_run");
    load_en = 1'b0; run = 1'b0;
    tick("rs_issue");
    check_eq("rs_issue.word", {instr_valid, instruction}, {1'b1, 20'hF_0001});
    tick("rs_halt");
    check_eq("rs_halt.halted", halted, 1'b1);

    // Asynchronous reset with a valid word on the output
    pulse_run();
    tick("ar_issue");
    #3 rst = 1'b0;
    #1 model_reset();
    compare_all("async_rst");
    check_eq("async_rst.all", {instruction, instr_valid, pc, halted}, {20'h0, 1'b0, 5'd0, 1'b0});
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) tick("idle_hold");

    // Randomized traffic
    for (int a = 0; a < 32; a++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      load_word(5'(a), {op, 16'($urandom)});
    end
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      run           = ($urandom_range(0, 9) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_en     = ($urandom_range(0, 7) == 0);
      branch_target = 5'($urandom);
      load_en       = ($urandom_range(0, 5) == 0);
      load_addr     = 5'($urandom);
      op            = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      load_data     = {op, 16'($urandom)};
      tick("rand");
    end
    load_en = 0; run = 0; stall = 0; branch_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
